regfile_32: RTL and testbench

Thirty-two-entry, single-write/dual-read processor register file with a per-register pending-write scoreboard. It sits directly upstream of the two 32:1 read-port multiplexers (`mux_32`) and owns the storage those muxes select from. The decode stage uses it to fetch operands and to detect read-after-write hazards. The writeback stage uses it to commit results.

---
 rtl/regfile_32.sv | 103 ++++++++++
 tb/tb_regfile_32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_32.sv
// rtl/regfile_32.sv - 32-entry 1W/2R register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.

module mux_32 #(
    parameter int WIDTH = 32
) (
    input  logic [31:0][WIDTH-1:0] din,
    input  logic [4:0]             sel,
    output logic [WIDTH-1:0]       dout
);
    assign dout = din[sel];
endmodule

module regfile_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       raddr_a,
    input  logic [4:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [31:0]      pending
);
    logic [31:0][WIDTH-1:0] mux_in;
    logic [WIDTH-1:0]       stored_a;
    logic [WIDTH-1:0]       stored_b;
    logic [31:0]            pending_nxt;

    // r0 has no storage; its mux leg is hardwired to zero.
    assign mux_in[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_q <= '0;
            end else if (we && (waddr == 5'(i))) begin
                r_q <= wdata;
            end
        end
        assign mux_in[i] = r_q;
    end

    // Clear first, then set: a new issue to the register being written back wins.
    always_comb begin
        pending_nxt = pending;
        if (we) begin
            pending_nxt[waddr] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    mux_32 #(.WIDTH(WIDTH)) u_mux_a (
        .din  (mux_in),
        .sel  (raddr_a),
        .dout (stored_a)
    );

    mux_32 #(.WIDTH(WIDTH)) u_mux_b (
        .din  (mux_in),
        .sel  (raddr_b),
        .dout (stored_b)
    );

`ifdef REGFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forwarding is suppressed during reset so every output reads zero.
    assign fwd_a = reset_n && we && (waddr != 5'd0) && (waddr == raddr_a);
    assign fwd_b = reset_n && we && (waddr != 5'd0) && (waddr == raddr_b);

    assign rdata_a = fwd_a ? wdata : stored_a;
    assign rdata_b = fwd_b ? wdata : stored_b;
    assign busy_a  = pending[raddr_a] & ~(we && (waddr == raddr_a));
    assign busy_b  = pending[raddr_b] & ~(we && (waddr == raddr_b));
`else
    assign rdata_a = stored_a;
    assign rdata_b = stored_b;
    assign busy_a  = pending[raddr_a];
    assign busy_b  = pending[raddr_b];
`endif

endmodule

// File: tb/tb_regfile_32.sv
// tb/tb_regfile_32.sv - randomized self-checking bench for regfile_32 against an array model.

module tb_regfile_32;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] pending;

    int tests = 0;
    int failed = 0;

    logic [31:0] mreg [32];
    logic        mpend [32];

    regfile_32 #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .raddr_a     (raddr_a),
        .raddr_b     (raddr_b),
        .rdata_a     (rdata_a),
        .rdata_b     (rdata_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .pending     (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = mpend[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] ra);
        if (!reset_n) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr != 0 && waddr == ra) return wdata;
`endif
        return mreg[ra];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] ra);
        if (!reset_n) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == ra) return '0;
`endif
        return {31'd0, mpend[ra]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = '0;
            mpend[i] = 1'b0;
        end
    endtask

    task automatic check_outs();
        chk("rdata_a", rdata_a, exp_data(raddr_a));
        chk("rdata_b", rdata_b, exp_data(raddr_b));
        chk("busy_a", {31'd0, busy_a}, exp_busy(raddr_a));
        chk("busy_b", {31'd0, busy_b}, exp_busy(raddr_b));
        chk("pending", pending, reset_n ? model_pending() : 32'd0);
    endtask

    // Drive one cycle: compare at negedge, advance model at posedge, leave at posedge+1.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] ra, input logic [4:0] rb);
        we = w; waddr = wa; wdata = wd;
        issue_valid = iv; issue_rd = ird;
        raddr_a = ra; raddr_b = rb;
        @(negedge clock);
        check_outs();
        @(posedge clock);
        if (!reset_n) begin
            model_clear();
        end else begin
            if (w && wa != 0) begin
                mreg[wa] = wd;
                mpend[wa] = 1'b0;
            end
            if (iv && ird != 0) mpend[ird] = 1'b1;
        end
        #1;
    endtask

    task automatic peek(input logic [4:0] ra, input logic [4:0] rb);
        we = 1'b0; issue_valid = 1'b0;
        raddr_a = ra; raddr_b = rb;
        #1;
    endtask

    initial begin
        model_clear();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 5, 31);
        chk("reset_pending", pending, 32'd0);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);

        step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        peek(0, 0);
        chk("r0_zero", rdata_a, 32'd0);
        chk("r0_pending", {31'd0, pending[0]}, 32'd0);

        step(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        step(1, 31, 32'hDEAD_BEEF, 0, 0, 0, 0);
        peek(5, 31);
        chk("r5_lit", rdata_a, 32'h1234_5678);
        chk("r31_lit", rdata_b, 32'hDEAD_BEEF);

        step(0, 0, 0, 1, 7, 7, 0);
        peek(7, 0);
        chk("issue7_pending", pending, 32'h0000_0080);
        chk("issue7_busy", {31'd0, busy_a}, 32'd1);

        step(1, 7, 32'hA5, 0, 0, 7, 0);
        peek(7, 0);
        chk("wb7_pending", pending, 32'd0);
        chk("wb7_data", rdata_a, 32'hA5);

        step(0, 0, 0, 1, 9, 9, 0);
        step(1, 9, 32'h99, 1, 9, 9, 0);
        peek(9, 0);
        chk("setwins_pend9", {31'd0, pending[9]}, 32'd1);
        chk("setwins_r9", rdata_a, 32'h99);

        step(0, 0, 0, 1, 4, 0, 0);
        step(1, 4, 32'h44, 1, 3, 3, 4);
        peek(3, 4);
        chk("iss3_wb4_pending", pending, 32'h0000_0208);

        step(0, 0, 0, 1, 12, 12, 0);
        step(1, 12, 32'h55, 1, 12, 12, 0);
        we = 1'b1; waddr = 5'd12; wdata = 32'h77; issue_valid = 1'b0; raddr_a = 5'd12;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_data", rdata_a, 32'h77);
        chk("bypass_busy", {31'd0, busy_a}, 32'd0);
`else
        chk("nobypass_data", rdata_a, 32'h55);
        chk("nobypass_busy", {31'd0, busy_a}, 32'd1);
`endif
        step(1, 12, 32'h77, 0, 0, 12, 0);
        peek(12, 0);
        chk("after_bypass_data", rdata_a, 32'h77);
        chk("after_bypass_busy", {31'd0, busy_a}, 32'd0);

        for (int c = 0; c < 10000; c++) begin
            logic narrow;
            narrow = ($urandom_range(0, 1) == 1);
            if (c == 5000) begin
                // Mid-stream async reset with an in-flight write that must be discarded.
                we = 1'b1; waddr = 5'd5; wdata = 32'hCAFE_F00D;
                issue_valid = 1'b1; issue_rd = 5'd6;
                raddr_a = 5'd5; raddr_b = 5'd31;
                #2;
                reset_n = 1'b0;
                #1;
                chk("midrst_rdata_a", rdata_a, 32'd0);
                chk("midrst_rdata_b", rdata_b, 32'd0);
                chk("midrst_busy", {30'd0, busy_a, busy_b}, 32'd0);
                chk("midrst_pending", pending, 32'd0);
                @(posedge clock);
                model_clear();
                #1;
                step(0, 0, 0, 0, 0, 5, 6);
                reset_n = 1'b1;
            end
            step($urandom_range(0, 1) == 1,
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
                 $urandom,
                 $urandom_range(0, 2) != 0,
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom),
                 narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
